mux_scan: RTL and testbench
===========================

// Module: mux_scan
//
// PURPOSE
//  Parametrised, registered N-channel multiplexer; successor to the 8:1 combinational mux.
//  Two modes:
//  - DIRECT: the channel given by SEL is sampled every cycle.
//  - SCAN: an internal pointer auto-cycles all channels with a programmable dwell time.
//  Each sample is tagged with its channel index and a valid strobe.
//  Sits between multi-source inputs and a single serial consumer (display/monitor/logger).
//
// PARAMETERS
//  N_CH     8   number of input channels (2..256)
//  W        1   width of each channel in bits
//  SEL_W    3   select/index width; must be >= clog2(N_CH)
//  DWELL_W  8   width of dwell-count input
//
// PORTS
//  clk      in   1          rising-edge clock; the only clock
//  rst_n    in   1          synchronous reset, active-low
//  X        in   N_CH*W     flat channel bus; channel k = X[k*W +: W]
//  SEL      in   SEL_W      channel select used in DIRECT mode
//  MODE     in   1          0 = DIRECT, 1 = SCAN
//  DWELL    in   DWELL_W    SCAN: idle cycles between samples (0 = sample every cycle)
//  EN       in   1          block enable
//  Y        out  W          registered selected data
//  Y_CH     out  SEL_W      channel index of the current Y
//  Y_VALID  out  1          high for exactly the cycles in which Y/Y_CH were just updated
//
// BEHAVIOUR
//  Reset: at a clk edge with rst_n=0:
//  - Y=0, Y_CH=0, Y_VALID=0, ptr=0, cnt=0, state=IDLE.
//  - Reset wins over all other inputs, including mid-scan.
//  State machine (IDLE, DIRECT, SCAN), evaluated at every edge with rst_n=1:
//  - EN=0 -> IDLE.
//  - EN=1, MODE=0 -> DIRECT.
//  - EN=1, MODE=1 -> SCAN.
//  IDLE:
//  - Y and Y_CH hold; Y_VALID=0; ptr and cnt hold.
//  DIRECT (edge where EN=1, MODE=0; applies on entry as well):
//  - If SEL < N_CH: Y<=X[SEL], Y_CH<=SEL, Y_VALID<=1. Latency is 1 clock.
//  - If SEL >= N_CH: Y<=0, Y_CH holds, Y_VALID<=0.
//  SCAN entry (edge where state!=SCAN and EN=1, MODE=1):
//  - ptr<=0, cnt<=0, Y_VALID<=0; no sample is taken on this edge.
//  SCAN steady (edge where state==SCAN and EN=1, MODE=1):
//  - If cnt >= DWELL: Y<=X[ptr], Y_CH<=ptr, Y_VALID<=1, cnt<=0.
//    ptr<=(ptr==N_CH-1) ? 0 : ptr+1.
//  - Otherwise: cnt<=cnt+1, Y_VALID<=0, Y and Y_CH hold.
//  - The first sample lands DWELL+1 edges after the entry edge.
//  - Sample period is DWELL+1 cycles.
//  - DWELL is read live; the >= comparison means that lowering DWELL below cnt fires on the next edge.
//  Wrap-around: ptr never exceeds N_CH-1, including for non-power-of-2 N_CH.
//  Re-entering SCAN from DIRECT or IDLE always restarts at channel 0.
//  Leaving SCAN discards ptr/cnt progress.
//  X changes between samples do not affect Y; Y only changes on a Y_VALID edge or on reset.
//  cnt is DWELL_W bits wide and cannot overflow, because it resets whenever cnt >= DWELL.
//
// TESTING
//  1. N_CH=8, W=4, X[k]=k+1, DIRECT, SEL=0..7 one per cycle
//     -> one cycle later Y=SEL+1, Y_CH=SEL, Y_VALID=1 every cycle.
//  2. N_CH=6, DIRECT, SEL=5 then SEL=7
//     -> Y=X[5], Y_VALID=1; then Y=0, Y_CH=5 (held), Y_VALID=0.
//  3. N_CH=8, SCAN, DWELL=2, 30 cycles
//     -> Y_VALID every 3rd cycle; Y_CH sequence 0,1,...,7,0,1 (wrap 7->0); first pulse 3 edges after entry.
//  4. SCAN, DWELL=0
//     -> Y_VALID high every cycle after entry; Y_CH increments each cycle, wraps at N_CH-1.
//  5. Mid-scan at Y_CH=4: EN=0 for 5 cycles
//     -> Y/Y_CH hold, Y_VALID=0; EN=1 restarts at ch0 after DWELL+1 edges.
//  6. rst_n=0 for one edge while scanning (ptr=5)
//     -> Y=0, Y_CH=0, Y_VALID=0; next SCAN sample is channel 0.

Source files
------------

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan
// Description : Registered N-channel multiplexer with DIRECT (SEL-driven) and
//               SCAN (auto-cycling pointer, programmable dwell) modes.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter int N_CH    = 8,
    parameter int W       = 1,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   X,
    input  logic [SEL_W-1:0]    SEL,
    input  logic                MODE,
    input  logic [DWELL_W-1:0]  DWELL,
    input  logic                EN,
    output logic [W-1:0]        Y,
    output logic [SEL_W-1:0]    Y_CH,
    output logic                Y_VALID
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // One extra bit so N_CH itself is representable when N_CH == 2**SEL_W.
    localparam logic [SEL_W:0]   C_N_CH_EXT = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] C_LAST_CH  = SEL_W'(N_CH - 1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [SEL_W-1:0]      r_ptr;
    logic [DWELL_W-1:0]    r_cnt;
    logic [W-1:0]          r_y;
    logic [SEL_W-1:0]      r_y_ch;
    logic                  r_y_valid;

    logic [SEL_W-1:0]      w_ptr_nxt;
    logic [DWELL_W-1:0]    w_cnt_nxt;
    logic [W-1:0]          w_y_nxt;
    logic [SEL_W-1:0]      w_y_ch_nxt;
    logic                  w_y_valid_nxt;

    logic [W-1:0]          w_ch [N_CH];
    logic [W-1:0]          w_sel_data;
    logic [W-1:0]          w_ptr_data;
    logic                  w_sel_ok;
    logic                  w_dwell_done;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_unpack
            assign w_ch[k] = X[k*W +: W];
        end
    endgenerate

    // Explicit compare-and-pick keeps out-of-range selects from indexing the array.
    always_comb begin
        w_sel_data = '0;
        w_ptr_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL == SEL_W'(i)) begin
                w_sel_data = w_ch[i];
            end
            if (r_ptr == SEL_W'(i)) begin
                w_ptr_data = w_ch[i];
            end
        end
    end

    assign w_sel_ok     = ({1'b0, SEL} < C_N_CH_EXT);
    assign w_dwell_done = (r_cnt >= DWELL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_ch_nxt    = r_y_ch;
        w_y_valid_nxt = 1'b0;

        if (!EN) begin
            w_state_nxt = ST_IDLE;
        end else if (MODE) begin
            w_state_nxt = ST_SCAN;
        end else begin
            w_state_nxt = ST_DIRECT;
        end

        case (w_state_nxt)
            ST_DIRECT: begin
                if (w_sel_ok) begin
                    w_y_nxt       = w_sel_data;
                    w_y_ch_nxt    = SEL;
                    w_y_valid_nxt = 1'b1;
                end else begin
                    w_y_nxt       = '0;
                end
            end
            ST_SCAN: begin
                if (r_state != ST_SCAN) begin
                    // Entry edge: restart from channel 0 without sampling.
                    w_ptr_nxt = '0;
                    w_cnt_nxt = '0;
                end else if (w_dwell_done) begin
                    w_y_nxt       = w_ptr_data;
                    w_y_ch_nxt    = r_ptr;
                    w_y_valid_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_ptr_nxt     = (r_ptr == C_LAST_CH) ? '0 : r_ptr + SEL_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_ch    <= w_y_ch_nxt;
            r_y_valid <= w_y_valid_nxt;
        end
    end

    assign Y       = r_y;
    assign Y_CH    = r_y_ch;
    assign Y_VALID = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan
// Description : Directed self-checking bench for mux_scan (8- and 6-channel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] x8;
    logic [23:0] x6;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  dwell;
    logic        en;
    logic [3:0]  y8, y6;
    logic [2:0]  y_ch8, y_ch6;
    logic        y_valid8, y_valid6;

    int n_cmp = 0;
    int n_err = 0;
    int exp_y, exp_ch;

    mux_scan #(.N_CH(8), .W(4), .SEL_W(3), .DWELL_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .X(x8), .SEL(sel), .MODE(mode),
        .DWELL(dwell), .EN(en), .Y(y8), .Y_CH(y_ch8), .Y_VALID(y_valid8)
    );

    mux_scan #(.N_CH(6), .W(4), .SEL_W(3), .DWELL_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .X(x6), .SEL(sel), .MODE(mode),
        .DWELL(dwell), .EN(en), .Y(y6), .Y_CH(y_ch6), .Y_VALID(y_valid6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input int ey, input int ech, input int ev);
        check({tag, ".y"},     int'(y8),       ey);
        check({tag, ".ch"},    int'(y_ch8),    ech);
        check({tag, ".valid"}, int'(y_valid8), ev);
    endtask

    initial begin
        // Channel k of the 8-channel DUT holds k+1; of the 6-channel DUT holds k+10.
        for (int k = 0; k < 8; k++) x8[k*4 +: 4] = 4'(k + 1);
        for (int k = 0; k < 6; k++) x6[k*4 +: 4] = 4'(k + 10);
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; dwell = 8'd0;
        tick(); tick();
        check8("reset", 0, 0, 0);
        check("reset6.valid", int'(y_valid6), 0);

        // DIRECT sweep of all channels, 1-cycle latency
        rst_n = 1'b1; en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check8($sformatf("direct%0d", s), s + 1, s, 1);
        end

        // Out-of-range select on the 6-channel DUT
        sel = 3'd5;
        tick();
        check("oor.in.y",     int'(y6),       15);
        check("oor.in.ch",    int'(y_ch6),    5);
        check("oor.in.valid", int'(y_valid6), 1);
        sel = 3'd7;
        tick();
        check("oor.out.y",     int'(y6),       0);
        check("oor.out.ch",    int'(y_ch6),    5);
        check("oor.out.valid", int'(y_valid6), 0);
        check8("oor.dut8", 8, 7, 1);

        // SCAN, DWELL=2: entry edge, then a sample every 3rd edge
        mode = 1'b1; dwell = 8'd2;
        tick();
        check8("scan2.entry", 8, 7, 0);
        exp_y = 8; exp_ch = 7;
        for (int i = 1; i <= 30; i++) begin
            if (i % 3 == 0) begin
                exp_ch = (i / 3 - 1) % 8;
                exp_y  = exp_ch + 1;
            end
            tick();
            check8($sformatf("scan2.e%0d", i), exp_y, exp_ch, (i % 3 == 0) ? 1 : 0);
        end

        // Through IDLE, then SCAN with DWELL=0: a sample every edge after entry
        en = 1'b0;
        tick();
        check8("idle", 2, 1, 0);
        en = 1'b1; dwell = 8'd0;
        tick();
        check8("scan0.entry", 2, 1, 0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            check8($sformatf("scan0.e%0d", i), (i - 1) % 8 + 1, (i - 1) % 8, 1);
        end

        // Pause at channel 4 with X disturbed; outputs must hold
        dwell = 8'd1; en = 1'b0;
        x8 = ~x8;
        for (int i = 0; i < 5; i++) begin
            tick();
            check8($sformatf("pause%0d", i), 5, 4, 0);
        end
        x8 = ~x8;
        en = 1'b1;
        tick();
        check8("resume.entry", 5, 4, 0);
        tick();
        check8("resume.e1", 5, 4, 0);
        tick();
        check8("resume.e2", 1, 0, 1);

        // Advance to ptr=5 (last sample ch4), then reset mid-scan
        for (int i = 0; i < 8; i++) tick();
        check8("prereset", 5, 4, 1);
        rst_n = 1'b0;
        tick();
        check8("midreset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check8("postreset.entry", 0, 0, 0);
        tick();
        check8("postreset.e1", 0, 0, 0);
        tick();
        check8("postreset.e2", 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
